// File: rtl/decim_pkg.sv
// Shared types and defaults for the polyphase decimation sequencer and its branch adder.
package decim_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FILL   = 3'd1,
        SETTLE = 3'd2,
        SUM    = 3'd3,
        HOLD   = 3'd4
    } state_e;

    localparam int DEF_DEC_FACTOR = 4;
    localparam int DEF_BRANCH_LAT = 3;
    localparam int DEF_IN_W       = 8;
    localparam int DEF_BR_W       = 17;

    // Enough headroom that summing dec_factor full-scale branch outputs cannot overflow.
    function automatic int acc_width(input int dec_factor, input int br_w);
        return br_w + $clog2(dec_factor);
    endfunction

endpackage

// File: rtl/decim_branch_adder.sv
// Combinational signed sum of DEC_FACTOR packed branch outputs, widened to ACC_W.
module decim_branch_adder
    import decim_pkg::*;
#(
    parameter int DEC_FACTOR = DEF_DEC_FACTOR,
    parameter int BR_W       = DEF_BR_W,
    parameter int ACC_W      = acc_width(DEC_FACTOR, BR_W)
) (
    input  logic [DEC_FACTOR*BR_W-1:0] lanes_i,
    output logic [ACC_W-1:0]           sum_o
);

    logic signed [ACC_W-1:0] lane_ext [DEC_FACTOR];
    logic signed [ACC_W-1:0] sum;

    genvar gi;
    generate
        for (gi = 0; gi < DEC_FACTOR; gi++) begin : g_ext
            assign lane_ext[gi] = ACC_W'($signed(lanes_i[gi*BR_W +: BR_W]));
        end
    endgenerate

    always_comb begin
        sum = '0;
        for (int k = 0; k < DEC_FACTOR; k++) begin
            sum = sum + lane_ext[k];
        end
    end

    assign sum_o = sum;

endmodule

// File: rtl/decim_phase_sequencer.sv
// Polyphase decimator commutator: steers a frame of input samples into branch hold registers,
// waits for the branches to settle, then emits their sum. Optional frame counter: DECIM_FRAME_CNT_EN.
module decim_phase_sequencer
    import decim_pkg::*;
#(
    parameter int DEC_FACTOR = DEF_DEC_FACTOR,
    parameter int BRANCH_LAT = DEF_BRANCH_LAT,
    parameter int IN_W       = DEF_IN_W,
    parameter int BR_W       = DEF_BR_W,
    parameter int ACC_W      = acc_width(DEC_FACTOR, BR_W),
    localparam int PH_W      = $clog2(DEC_FACTOR),
    localparam int CNT_W     = (BRANCH_LAT > 1) ? $clog2(BRANCH_LAT) : 1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       enable,
    input  logic                       in_valid,
    input  logic [IN_W-1:0]            in_data,
    output logic                       in_ready,
    output logic [DEC_FACTOR*IN_W-1:0] br_in,
    input  logic [DEC_FACTOR*BR_W-1:0] br_out,
    output logic [PH_W-1:0]            phase,
    output logic                       out_valid,
    output logic [ACC_W-1:0]           out_data,
    input  logic                       out_ready
`ifdef DECIM_FRAME_CNT_EN
    ,
    output logic [15:0]                frame_cnt
`endif
);

    state_e                     state_q, state_d;
    logic [PH_W-1:0]            phase_q, phase_d;
    logic [CNT_W-1:0]           cnt_q, cnt_d;
    logic [DEC_FACTOR*IN_W-1:0] br_in_q, br_in_d;
    logic                       out_valid_q, out_valid_d;
    logic [ACC_W-1:0]           out_data_q, out_data_d;
    logic [ACC_W-1:0]           sum_w;
`ifdef DECIM_FRAME_CNT_EN
    logic [15:0]                frame_cnt_q, frame_cnt_d;
`endif

    decim_branch_adder #(
        .DEC_FACTOR (DEC_FACTOR),
        .BR_W       (BR_W),
        .ACC_W      (ACC_W)
    ) u_adder (
        .lanes_i (br_out),
        .sum_o   (sum_w)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            phase_q     <= '0;
            cnt_q       <= '0;
            br_in_q     <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
`ifdef DECIM_FRAME_CNT_EN
            frame_cnt_q <= '0;
`endif
        end else begin
            state_q     <= state_d;
            phase_q     <= phase_d;
            cnt_q       <= cnt_d;
            br_in_q     <= br_in_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
`ifdef DECIM_FRAME_CNT_EN
            frame_cnt_q <= frame_cnt_d;
`endif
        end
    end

    always_comb begin
        state_d     = state_q;
        phase_d     = phase_q;
        cnt_d       = cnt_q;
        br_in_d     = br_in_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
`ifdef DECIM_FRAME_CNT_EN
        frame_cnt_d = frame_cnt_q;
`endif
        // Dropping enable discards any partial frame so the next one starts cleanly at lane 0.
        if (!enable) begin
            state_d     = IDLE;
            phase_d     = '0;
            cnt_d       = '0;
            br_in_d     = '0;
            out_valid_d = 1'b0;
`ifdef DECIM_FRAME_CNT_EN
            frame_cnt_d = '0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    state_d = FILL;
                end
                FILL: begin
                    if (in_valid) begin
                        for (int k = 0; k < DEC_FACTOR; k++) begin
                            if (phase_q == PH_W'(k)) begin
                                br_in_d[k*IN_W +: IN_W] = in_data;
                            end
                        end
                        if (phase_q == PH_W'(DEC_FACTOR - 1)) begin
                            phase_d = '0;
                            cnt_d   = '0;
                            state_d = SETTLE;
                        end else begin
                            phase_d = phase_q + PH_W'(1);
                        end
                    end
                end
                SETTLE: begin
                    if (cnt_q == CNT_W'(BRANCH_LAT - 1)) begin
                        state_d = SUM;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                SUM: begin
                    out_data_d  = sum_w;
                    out_valid_d = 1'b1;
                    state_d     = HOLD;
                end
                HOLD: begin
                    if (out_ready) begin
                        out_valid_d = 1'b0;
                        state_d     = FILL;
`ifdef DECIM_FRAME_CNT_EN
                        frame_cnt_d = frame_cnt_q + 16'd1;
`endif
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    assign in_ready  = (state_q == FILL);
    assign br_in     = br_in_q;
    assign phase     = phase_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
`ifdef DECIM_FRAME_CNT_EN
    assign frame_cnt = frame_cnt_q;
`endif

endmodule

// File: tb/tb_decim_phase_sequencer.sv
// Self-checking bench for decim_phase_sequencer with a 3-stage x512 branch model per lane.
// Expected sums and latencies come from the frame samples directly; frame_cnt checked when DECIM_FRAME_CNT_EN is defined.
module tb_decim_phase_sequencer;

    localparam int DF    = 4;
    localparam int LAT   = 3;
    localparam int IN_W  = 8;
    localparam int BR_W  = 17;
    localparam int ACC_W = 19;

    logic                  clk = 1'b0;
    logic                  rst_n;
    logic                  enable;
    logic                  in_valid;
    logic [IN_W-1:0]       in_data;
    logic                  in_ready;
    logic [DF*IN_W-1:0]    br_in;
    logic [DF*BR_W-1:0]    br_out;
    logic [$clog2(DF)-1:0] phase;
    logic                  out_valid;
    logic [ACC_W-1:0]      out_data;
    logic                  out_ready;
`ifdef DECIM_FRAME_CNT_EN
    logic [15:0]           frame_cnt;
`endif

    int n_total = 0;
    int n_bad   = 0;
    int cyc     = 0;
    int frames_done = 0;
    logic [7:0] fr [DF];

    decim_phase_sequencer #(
        .DEC_FACTOR (DF),
        .BRANCH_LAT (LAT),
        .IN_W       (IN_W),
        .BR_W       (BR_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .enable    (enable),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .br_in     (br_in),
        .br_out    (br_out),
        .phase     (phase),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready)
`ifdef DECIM_FRAME_CNT_EN
        ,
        .frame_cnt (frame_cnt)
`endif
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Branch model: three register stages, output = 512 * input sample.
    logic [BR_W-1:0] st1 [DF];
    logic [BR_W-1:0] st2 [DF];
    logic [BR_W-1:0] st3 [DF];

    function automatic logic [BR_W-1:0] scale(input logic [IN_W-1:0] s);
        int v;
        v = int'($signed(s)) * 512;
        return v[BR_W-1:0];
    endfunction

    always @(posedge clk) begin
        for (int k = 0; k < DF; k++) begin
            st1[k] <= scale(br_in[k*IN_W +: IN_W]);
            st2[k] <= st1[k];
            st3[k] <= st2[k];
        end
    end

    always_comb begin
        br_out = '0;
        for (int k = 0; k < DF; k++) br_out[k*BR_W +: BR_W] = st3[k];
    end

    task automatic check(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
        n_total++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic logic signed [63:0] lane(input int k);
        return 64'($signed(br_in[k*IN_W +: IN_W]));
    endfunction

    // Called at a negedge; returns at the negedge following the accepting edge.
    task automatic push(input logic [7:0] d, output int acc_edge);
        int tries;
        tries = 0;
        in_valid = 1'b1;
        in_data  = d;
        while (!in_ready && tries < 100) begin
            @(negedge clk);
            tries++;
        end
        if (!in_ready) begin
            check("push_timeout", in_ready, 1);
            acc_edge = -1;
            in_valid = 1'b0;
        end else begin
            @(posedge clk);
            #1 acc_edge = cyc;
            @(negedge clk);
            in_valid = 1'b0;
        end
    endtask

    task automatic wait_out(output int v_edge);
        int tries;
        tries = 0;
        while (!out_valid && tries < 200) begin
            @(negedge clk);
            tries++;
        end
        if (!out_valid) begin
            check("out_timeout", out_valid, 1);
            v_edge = -1;
        end else begin
            v_edge = cyc;
        end
    endtask

    // Sends fr[] with random idle gaps, then checks latency, sum and the output handshake.
    task automatic run_frame(input string tag, input int gap_max, input int stall);
        int a, v;
        longint exp;
        exp = 0;
        a = -1;
        out_ready = (stall == 0);
        for (int i = 0; i < DF; i++) begin
            repeat ($urandom_range(gap_max, 0)) @(negedge clk);
            push(fr[i], a);
            exp += longint'($signed(fr[i])) * 512;
        end
        check({tag, "_ready_after_last"}, in_ready, 0);
        wait_out(v);
        check({tag, "_latency"}, v - a, LAT + 1);
        check({tag, "_sum"}, $signed(out_data), exp);
        for (int s = 0; s < stall; s++) begin
            in_valid = 1'b1;
            in_data  = 8'h5A;
            @(negedge clk);
            check($sformatf("%s_stall%0d_valid", tag, s), out_valid, 1);
            check($sformatf("%s_stall%0d_data", tag, s), $signed(out_data), exp);
            check($sformatf("%s_stall%0d_inready", tag, s), in_ready, 0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        check({tag, "_valid_drop"}, out_valid, 0);
        check({tag, "_phase_idle"}, phase, 0);
        frames_done++;
        $display("frame %s: sum=%0d latency=%0d", tag, exp, v - a);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int a, v;
        int pat [7];
        int eph [7];
        logic [7:0] smp [4];
        int j;

        pat = '{1, 0, 0, 1, 1, 0, 1};
        eph = '{0, 1, 1, 1, 2, 3, 3};
        smp = '{8'd5, 8'd6, 8'd7, 8'd8};

        rst_n = 1'b0; enable = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
        repeat (5) @(negedge clk);
        check("rst_in_ready", in_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_phase", phase, 0);
        check("rst_br_in", br_in, 0);
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_in_ready", in_ready, 0);
        enable = 1'b1;
        @(negedge clk);
        check("fill_in_ready", in_ready, 1);

        fr = '{8'd1, 8'd2, 8'd3, 8'd4};
        run_frame("f1234", 0, 0);
        fr = '{8'h80, 8'h80, 8'h80, 8'h80};
        run_frame("fneg", 0, 0);
        fr = '{8'h7F, 8'h7F, 8'h7F, 8'h7F};
        run_frame("fpos", 0, 0);
        for (int i = 0; i < DF; i++) fr[i] = 8'($urandom);
        run_frame("fstall", 0, 10);

        // Gapped in_valid: phase only advances on accepted samples.
        j = 0;
        a = -1;
        for (int i = 0; i < 7; i++) begin
            check($sformatf("gap_phase%0d", i), phase, eph[i]);
            in_valid = pat[i][0];
            in_data  = (pat[i] != 0) ? smp[j] : 8'hAA;
            @(posedge clk);
            #1 if (pat[i] != 0) begin
                a = cyc;
                j++;
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
        check("gap_phase_wrap", phase, 0);
        for (int k = 0; k < DF; k++) check($sformatf("gap_lane%0d", k), lane(k), 5 + k);
        wait_out(v);
        check("gap_latency", v - a, LAT + 1);
        check("gap_sum", $signed(out_data), 13312);
        @(negedge clk);
        check("gap_valid_drop", out_valid, 0);
        frames_done++;
        $display("frame gap: sum=13312 latency=%0d", v - a);

        // Abort after two samples; the partial frame must vanish.
        push(8'd9, a);
        push(8'd10, a);
        check("abort_pre_phase", phase, 2);
        enable = 1'b0;
        @(negedge clk);
        check("abort_phase", phase, 0);
        check("abort_br_in", br_in, 0);
        check("abort_in_ready", in_ready, 0);
        frames_done = 0;
`ifdef DECIM_FRAME_CNT_EN
        check("abort_frame_cnt", frame_cnt, 0);
`endif
        enable = 1'b1;
        @(negedge clk);
        check("reen_in_ready", in_ready, 1);
        check("reen_phase", phase, 0);
        fr = '{8'd1, 8'd1, 8'd1, 8'd1};
        run_frame("fones", 0, 0);

        for (int n = 0; n < 15; n++) begin
            for (int i = 0; i < DF; i++) fr[i] = 8'($urandom);
            run_frame($sformatf("rnd%0d", n), 2, $urandom_range(3, 0));
        end
`ifdef DECIM_FRAME_CNT_EN
        check("frame_cnt", frame_cnt, frames_done);
`endif

        // Asynchronous reset in the middle of SETTLE.
        fr = '{8'd3, 8'd4, 8'd5, 8'd6};
        for (int i = 0; i < DF; i++) push(fr[i], a);
        #2 rst_n = 1'b0;
        #1;
        check("arst_in_ready", in_ready, 0);
        check("arst_out_valid", out_valid, 0);
        check("arst_out_data", out_data, 0);
        check("arst_phase", phase, 0);
        check("arst_br_in", br_in, 0);
`ifdef DECIM_FRAME_CNT_EN
        check("arst_frame_cnt", frame_cnt, 0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        for (int i = 0; i < DF; i++) fr[i] = 8'($urandom);
        run_frame("post_rst", 1, 2);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
